// File: rtl/adc_spi_rx_monitor_if.sv
// Bus bundle for adc_spi_rx_monitor: the 3-wire ADC config bus tap plus the monitor's results.
// master = bus/readback side (writer model, host); slave = the monitor itself.
interface adc_spi_rx_monitor_if #(
    parameter int BITS = 24
);
    logic [11:0]     CS;
    logic            SCLK;
    logic            SDATA;
    logic [11:0]     SEL_MASK;
    logic            WORD_VLD;
    logic [BITS-1:0] WORD;
    logic [11:0]     WORD_CS;
    logic            FRAME_ERR;
    logic [7:0]      ERR_CNT;
    logic [4:0]      RD_ADDR;
    logic [BITS-1:0] RD_DATA;

    modport master (
        output CS, SCLK, SDATA, SEL_MASK, RD_ADDR,
        input  WORD_VLD, WORD, WORD_CS, FRAME_ERR, ERR_CNT, RD_DATA
    );

    modport slave (
        input  CS, SCLK, SDATA, SEL_MASK, RD_ADDR,
        output WORD_VLD, WORD, WORD_CS, FRAME_ERR, ERR_CNT, RD_DATA
    );
endinterface

// File: rtl/adc_spi_rx_monitor.sv
// Receive-side monitor for the 3-wire ADC config bus: deserializes frames, flags framing errors.
// Define ADC_RX_SHADOW_EN to add the 32-entry shadow copy of the ADC registers for readback.
module adc_spi_rx_monitor #(
    parameter int BITS    = 24,
    parameter int SYNC    = 2,
    parameter int TIMEOUT = 64
) (
    input logic                CLK,
    input logic                RST,
    adc_spi_rx_monitor_if.slave bus
);
    localparam int CNT_W = $clog2(BITS + 2);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_SHIFT, S_END} state_t;

    logic [11:0]      cs_pipe [SYNC];
    logic [SYNC-1:0]  sclk_pipe;
    logic [SYNC-1:0]  sdata_pipe;
    logic             sclk_d;
    logic [11:0]      cs_s;
    logic             sclk_s, sdata_s, rise, cs_act;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic [BITS-1:0]  shreg;
    logic [11:0]      cs_cap;
    logic             word_vld_q, frame_err_q;
    logic [BITS-1:0]  word_q;
    logic [11:0]      word_cs_q;
    logic [7:0]       err_cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Synchronizers are left unreset so a reset mid-frame still sees CS high and parks in WAIT.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments make each stage take the previous stage's old value.
        cs_pipe[0]    <= bus.CS;
        sclk_pipe[0]  <= bus.SCLK;
        sdata_pipe[0] <= bus.SDATA;
        for (int i = 1; i < SYNC; i++) begin
            cs_pipe[i]    <= cs_pipe[i-1];
            sclk_pipe[i]  <= sclk_pipe[i-1];
            sdata_pipe[i] <= sdata_pipe[i-1];
        end
        sclk_d <= sclk_s;
    end

    assign cs_s    = cs_pipe[SYNC-1];
    assign sclk_s  = sclk_pipe[SYNC-1];
    assign sdata_s = sdata_pipe[SYNC-1];
    assign rise    = sclk_s & ~sclk_d;
    assign cs_act  = |(cs_s & bus.SEL_MASK);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= S_WAIT;
            cnt         <= '0;
            tmo         <= '0;
            word_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            word_q      <= '0;
            word_cs_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            word_vld_q  <= 1'b0;
            frame_err_q <= 1'b0;
            unique case (state)
                S_WAIT: if (!cs_act) state <= S_IDLE;
                S_IDLE: begin
                    if (cs_act) begin
                        state  <= S_SHIFT;
                        cnt    <= '0;
                        tmo    <= '0;
                        cs_cap <= cs_s & bus.SEL_MASK;
                    end
                end
                S_SHIFT: begin
                    if (rise) begin
                        shreg <= {shreg[BITS-2:0], sdata_s};
                        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
                        tmo <= '0;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                    // Frame end wins over a coincident timeout; a rise on the last cycle is kept.
                    if (!cs_act) begin
                        state <= S_END;
                    end else if (!rise && tmo == TMO_LAST) begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc(err_cnt_q);
                        state       <= S_WAIT;
                    end
                end
                S_END: begin
                    if (cnt == CNT_FULL) begin
                        word_q     <= shreg;
                        word_cs_q  <= cs_cap;
                        word_vld_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                        err_cnt_q   <= sat_inc(err_cnt_q);
                    end
                    state <= S_IDLE;
                end
                default: state <= S_WAIT;
            endcase
        end
    end

    assign bus.WORD_VLD  = word_vld_q;
    assign bus.WORD      = word_q;
    assign bus.WORD_CS   = word_cs_q;
    assign bus.FRAME_ERR = frame_err_q;
    assign bus.ERR_CNT   = err_cnt_q;

`ifdef ADC_RX_SHADOW_EN
    function automatic logic [4:0] shadow_index(input logic [7:0] addr);
        case (addr)
            8'h00: return 5'h00;
            8'h01: return 5'h01;
            8'h0F: return 5'h02;
            8'h11: return 5'h03;
            8'h12: return 5'h04;
            8'h14: return 5'h05;
            8'h24: return 5'h06;
            8'h25: return 5'h07;
            8'h26: return 5'h08;
            8'h27: return 5'h09;
            8'h2A: return 5'h0A;
            8'h2B: return 5'h0B;
            8'h42: return 5'h0C;
            8'h45: return 5'h0D;
            8'h46: return 5'h0E;
            8'hE2: return 5'h0F;
            8'hE3: return 5'h10;
            default: return 5'h1F;
        endcase
    endfunction

    logic [BITS-1:0] shadow_ram [32];
    logic            wr_en;
    logic [4:0]      wr_idx;

    assign wr_en  = !RST && (state == S_END) && (cnt == CNT_FULL);
    assign wr_idx = shadow_index(shreg[BITS-1:BITS-8]);

    // NOTE: the RAM has no reset; it keeps the last configuration across RST by design.
    always_ff @(posedge CLK) begin
        if (wr_en) shadow_ram[wr_idx] <= shreg;
    end

    assign bus.RD_DATA = shadow_ram[bus.RD_ADDR];
`else
    logic rd_addr_unused;
    assign rd_addr_unused = ^bus.RD_ADDR;
    assign bus.RD_DATA    = '0;
`endif
endmodule

// File: tb/tb_adc_spi_rx_monitor.sv
// Self-checking bench for adc_spi_rx_monitor: table-driven frames plus hand-written corner cases.
// Pulses are matched against a scoreboard queue filled when each frame is driven.
module tb_adc_spi_rx_monitor;
    localparam int SYNC = 2;
    localparam int LAT  = SYNC + 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    adc_spi_rx_monitor_if #(.BITS(24)) bus ();

    adc_spi_rx_monitor #(.BITS(24), .SYNC(SYNC), .TIMEOUT(64)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          good;
        logic [23:0] word;
        logic [11:0] cs;
    } exp_t;

    typedef struct {
        logic [23:0] word;
        logic [11:0] cs;
        logic [11:0] sel;
        int          nbits;
        int          kind;    // 0 no activity, 1 good word, 2 frame error
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    vec_t        vecs[9];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] m_word = '0;
    logic [7:0]  m_err  = '0;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_good(input logic [23:0] w, input logic [11:0] cs);
        exp_t e;
        e.good = 1'b1; e.word = w; e.cs = cs;
        sb_q.push_back(e);
        m_word = w;
    endtask

    task automatic expect_err();
        exp_t e;
        e.good = 1'b0; e.word = '0; e.cs = '0;
        sb_q.push_back(e);
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
    endtask

    // Scoreboard side: every output pulse must match the oldest pending expectation.
    always @(negedge CLK) begin
        if (!RST && (bus.WORD_VLD || bus.FRAME_ERR)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {30'b0, bus.WORD_VLD, bus.FRAME_ERR}, 32'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", {30'b0, bus.WORD_VLD, bus.FRAME_ERR}, mon_e.good ? 32'h2 : 32'h1);
                if (mon_e.good) begin
                    check("word", {8'h0, bus.WORD}, {8'h0, mon_e.word});
                    check("word_cs", {20'h0, bus.WORD_CS}, {20'h0, mon_e.cs});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.SCLK  = 1'b0;
        bus.SDATA = b;
        tick(1);
        bus.SCLK  = 1'b1;
        tick(1);
    endtask

    task automatic send_bits(input logic [23:0] w, input int n);
        logic [23:0] t;
        t = w;
        for (int i = 0; i < n; i++) begin
            send_bit(t[23]);
            t = {t[22:0], 1'b0};
        end
    endtask

    // Drops CS and reports how many CLK edges later a pulse appeared (-1 if none within 12).
    task automatic end_frame(output int l);
        bus.CS = '0;
        l = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK);
            #1;
            if (bus.WORD_VLD || bus.FRAME_ERR) begin
                l = k;
                break;
            end
        end
        tick(2);
    endtask

    task automatic send_frame(input logic [23:0] w, input logic [11:0] cs, input int n, output int l);
        bus.CS = cs;
        tick(2);
        send_bits(w, n);
        tick(1);
        end_frame(l);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{24'h0F0200, 12'h004, 12'hFFF, 24, 1};
        vecs[1] = '{24'h123456, 12'h004, 12'hFFF, 23, 2};
        vecs[2] = '{24'hA5C3E1, 12'h800, 12'hFFF, 24, 1};
        vecs[3] = '{24'h000000, 12'h001, 12'hFFF, 24, 1};
        vecs[4] = '{24'hFFFFFF, 12'h010, 12'hFFF, 25, 2};
        vecs[5] = '{24'h2A5A5A, 12'h020, 12'hFFF, 24, 1};
        vecs[6] = '{24'h0F0200, 12'h800, 12'h001, 24, 0};
        vecs[7] = '{24'h13579B, 12'h003, 12'h002, 24, 1};
        vecs[8] = '{24'h800000, 12'h040, 12'hFFF, 1,  2};

        bus.CS = '0; bus.SCLK = 1'b1; bus.SDATA = 1'b0;
        bus.SEL_MASK = 12'hFFF; bus.RD_ADDR = '0;
        RST = 1'b1;
        tick(5);
        check("rst_word_vld",  {31'b0, bus.WORD_VLD}, 32'h0);
        check("rst_frame_err", {31'b0, bus.FRAME_ERR}, 32'h0);
        check("rst_word",      {8'h0, bus.WORD}, 32'h0);
        check("rst_word_cs",   {20'h0, bus.WORD_CS}, 32'h0);
        check("rst_err_cnt",   {24'h0, bus.ERR_CNT}, 32'h0);
        RST = 1'b0;
        tick(2);

        for (int i = 0; i < 9; i++) begin
            bus.SEL_MASK = vecs[i].sel;
            if (vecs[i].kind == 1) expect_good(vecs[i].word, vecs[i].cs & vecs[i].sel);
            else if (vecs[i].kind == 2) expect_err();
            send_frame(vecs[i].word, vecs[i].cs, vecs[i].nbits, lat);
            check($sformatf("v%0d_latency", i), lat, (vecs[i].kind == 0) ? -1 : LAT);
            check($sformatf("v%0d_word", i), {8'h0, bus.WORD}, {8'h0, m_word});
            check($sformatf("v%0d_err_cnt", i), {24'h0, bus.ERR_CNT}, {24'h0, m_err});
            check($sformatf("v%0d_drained", i), sb_q.size(), 0);
        end
        bus.SEL_MASK = 12'hFFF;

        // SCLK stalls after 10 bits; a full frame sent before CS drops must be ignored.
        bus.CS = 12'h004;
        tick(2);
        send_bits(24'hABCDEF, 10);
        expect_err();
        tick(80);
        check("timeout_err_seen", sb_q.size(), 0);
        check("timeout_err_cnt", {24'h0, bus.ERR_CNT}, {24'h0, m_err});
        send_bits(24'h010010, 24);
        tick(1);
        end_frame(lat);
        check("after_timeout_ignored", lat, -1);
        check("after_timeout_word", {8'h0, bus.WORD}, {8'h0, m_word});
        expect_good(24'h11BEEF, 12'h004);
        send_frame(24'h11BEEF, 12'h004, 24, lat);
        check("after_timeout_clean", lat, LAT);

        // Last SCLK rise arrives together with CS falling.
        bus.CS = 12'h100;
        tick(2);
        send_bits(24'h271234, 23);
        expect_good(24'h271234, 12'h100);
        bus.SCLK  = 1'b0;
        bus.SDATA = 1'b0;
        tick(1);
        bus.SCLK  = 1'b1;
        end_frame(lat);
        check("coincident_rise_latency", lat, LAT);
        check("coincident_rise_word", {8'h0, bus.WORD}, 32'h00271234);

        // Reset in the middle of a frame, released with CS still high.
        bus.CS = 12'h004;
        tick(2);
        send_bits(24'h55AA55, 12);
        RST = 1'b1;
        tick(3);
        RST = 1'b0;
        m_word = '0;
        m_err  = '0;
        send_bits(24'hA55000, 12);
        tick(1);
        end_frame(lat);
        check("reset_frame_ignored", lat, -1);
        check("reset_word_cleared", {8'h0, bus.WORD}, 32'h0);
        check("reset_err_cleared", {24'h0, bus.ERR_CNT}, 32'h0);
        expect_good(24'h428000, 12'h004);
        send_frame(24'h428000, 12'h004, 24, lat);
        check("post_reset_latency", lat, LAT);
        check("post_reset_word", {8'h0, bus.WORD}, 32'h00428000);

        // Shadow register readback.
        expect_good(24'h450001, 12'h001);
        send_frame(24'h450001, 12'h001, 24, lat);
        expect_good(24'h99ABCD, 12'h001);
        send_frame(24'h99ABCD, 12'h001, 24, lat);
        bus.RD_ADDR = 5'h0D; #1;
`ifdef ADC_RX_SHADOW_EN
        check("shadow_0d", {8'h0, bus.RD_DATA}, 32'h00450001);
        bus.RD_ADDR = 5'h1F; #1;
        check("shadow_1f", {8'h0, bus.RD_DATA}, 32'h0099ABCD);
        bus.RD_ADDR = 5'h02; #1;
        check("shadow_02", {8'h0, bus.RD_DATA}, 32'h000F0200);
        bus.RD_ADDR = 5'h0C; #1;
        check("shadow_0c", {8'h0, bus.RD_DATA}, 32'h00428000);
`else
        check("no_shadow_0d", {8'h0, bus.RD_DATA}, 32'h0);
        bus.RD_ADDR = 5'h1F; #1;
        check("no_shadow_1f", {8'h0, bus.RD_DATA}, 32'h0);
`endif

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            expect_err();
            send_frame(24'h800000, 12'h002, 1, lat);
        end
        check("err_cnt_saturated", {24'h0, bus.ERR_CNT}, 32'hFF);
        check("err_model_saturated", {24'h0, bus.ERR_CNT}, {24'h0, m_err});
        check("final_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
